// File: rtl/trigger_wheel_gen.sv
// Synthetic N-minus-M trigger wheel generator for EFI bench work.
// Produces a VR/hall style tooth train with a sync gap, per-tooth period ramping and clamping.
module trigger_wheel_gen #(
    parameter int unsigned TEETH_TOTAL = 60,
    parameter int unsigned MISSING     = 2,
    parameter int unsigned PER_W       = 24,
    parameter int unsigned REV_W       = 16,
    parameter bit          INVERT      = 1'b0,
    localparam int unsigned N          = TEETH_TOTAL - MISSING,
    localparam int unsigned IW         = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk_efi,
    input  logic             rst,
    input  logic             enable,
    input  logic [PER_W-1:0] period_init,
    input  logic [PER_W-1:0] period_step,
    input  logic [PER_W-1:0] period_min,
    input  logic [PER_W-1:0] period_max,
    output logic             vrout,
    output logic [IW-1:0]    tooth_idx,
    output logic             sync,
    output logic [REV_W-1:0] rev_count,
    output logic             running,
    output logic [PER_W-1:0] cur_period
);

    localparam int unsigned GapReps = 2 * MISSING + 1;
    localparam int unsigned RW      = $clog2(GapReps + 1);

    typedef enum logic [1:0] {StIdle, StLow, StHigh} state_e;

    state_e           state_q;
    logic             vrout_q;
    logic [IW-1:0]    tooth_idx_q;
    logic             sync_q;
    logic [REV_W-1:0] rev_count_q;
    logic             running_q;
    logic [PER_W-1:0] cur_period_q;
    logic [PER_W-1:0] cnt_q;
    logic [RW-1:0]    rep_q;

    logic [PER_W+1:0] step_sum;
    logic [PER_W-1:0] period_start;
    logic [PER_W-1:0] period_next;
    logic [IW-1:0]    idx_next;
    logic             last_rep;

    // Unsigned clamp; the sign bit of the widened sum flags a negative result.
    function automatic logic [PER_W-1:0] clamp(input logic [PER_W+1:0] x,
                                               input logic [PER_W-1:0] mn,
                                               input logic [PER_W-1:0] mx);
        logic [PER_W+1:0] lo;
        logic [PER_W+1:0] v;
        lo = {2'b00, (mn == '0) ? {{(PER_W-1){1'b0}}, 1'b1} : mn};
        if (x[PER_W+1] || (x < lo)) v = lo;
        else                        v = x;
        if (v > {2'b00, mx})        v = {2'b00, mx};
        return v[PER_W-1:0];
    endfunction

    function automatic logic [PER_W-1:0] cnt_load(input logic [PER_W-1:0] p);
        return (p == '0) ? '0 : p - PER_W'(1);
    endfunction

    always_comb begin
        step_sum     = {2'b00, cur_period_q} + {{2{period_step[PER_W-1]}}, period_step};
        period_next  = clamp(step_sum, period_min, period_max);
        period_start = clamp({2'b00, period_init}, period_min, period_max);
        idx_next     = (tooth_idx_q == IW'(N - 1)) ? '0 : tooth_idx_q + IW'(1);
        last_rep     = (tooth_idx_q != '0) || (rep_q == RW'(GapReps - 1));
    end

    always_ff @(posedge clk_efi) begin
        if (rst) begin
            state_q      <= StIdle;
            vrout_q      <= 1'b0;
            tooth_idx_q  <= '0;
            sync_q       <= 1'b0;
            rev_count_q  <= '0;
            running_q    <= 1'b0;
            cur_period_q <= '0;
            cnt_q        <= '0;
            rep_q        <= '0;
        end else begin
            sync_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q      <= StLow;
                        tooth_idx_q  <= IW'(1);
                        cur_period_q <= period_start;
                        cnt_q        <= cnt_load(period_start);
                        rep_q        <= '0;
                        running_q    <= 1'b1;
                        vrout_q      <= 1'b0;
                    end
                end
                StLow: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - PER_W'(1);
                    end else if (!last_rep) begin
                        // Gap is built by repeating the low phase, not by scaling the period.
                        rep_q <= rep_q + RW'(1);
                        cnt_q <= cnt_load(cur_period_q);
                    end else begin
                        state_q <= StHigh;
                        vrout_q <= 1'b1;
                        cnt_q   <= cnt_load(cur_period_q);
                        rep_q   <= '0;
                        if (tooth_idx_q == '0) begin
                            sync_q      <= 1'b1;
                            rev_count_q <= rev_count_q + REV_W'(1);
                        end
                    end
                    if (!enable) begin
                        state_q   <= StIdle;
                        vrout_q   <= 1'b0;
                        running_q <= 1'b0;
                    end
                end
                StHigh: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - PER_W'(1);
                    end else begin
                        state_q     <= StLow;
                        vrout_q     <= 1'b0;
                        tooth_idx_q <= idx_next;
                        if (idx_next != '0) begin
                            cur_period_q <= period_next;
                            cnt_q        <= cnt_load(period_next);
                        end else begin
                            cnt_q <= cnt_load(cur_period_q);
                        end
                    end
                    if (!enable) begin
                        state_q      <= StIdle;
                        vrout_q      <= 1'b0;
                        running_q    <= 1'b0;
                        tooth_idx_q  <= tooth_idx_q;
                        cur_period_q <= cur_period_q;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign vrout      = vrout_q ^ INVERT;
    assign tooth_idx  = tooth_idx_q;
    assign sync       = sync_q;
    assign rev_count  = rev_count_q;
    assign running    = running_q;
    assign cur_period = cur_period_q;

endmodule

// File: tb/tb_trigger_wheel_gen.sv
// Bench for trigger_wheel_gen: a phase-by-phase trace generator fills a stimulus/expectation queue
// that drives a default instance and an INVERT=1, REV_W=2 instance in lockstep.
module tb_trigger_wheel_gen;

    localparam int N    = 58;
    localparam int GAPM = 5;

    logic        clk_efi = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic [23:0] period_init = '0, period_step = '0, period_min = '0, period_max = '0;

    logic        vr_a, sy_a, run_a, vr_b, sy_b, run_b;
    logic [5:0]  idx_a, idx_b;
    logic [15:0] rev_a;
    logic [1:0]  rev_b;
    logic [23:0] cur_a, cur_b;

    always #5 clk_efi = ~clk_efi;

    trigger_wheel_gen dut_a (
        .clk_efi(clk_efi), .rst(rst), .enable(enable), .period_init(period_init),
        .period_step(period_step), .period_min(period_min), .period_max(period_max),
        .vrout(vr_a), .tooth_idx(idx_a), .sync(sy_a), .rev_count(rev_a), .running(run_a),
        .cur_period(cur_a)
    );

    trigger_wheel_gen #(.REV_W(2), .INVERT(1'b1)) dut_b (
        .clk_efi(clk_efi), .rst(rst), .enable(enable), .period_init(period_init),
        .period_step(period_step), .period_min(period_min), .period_max(period_max),
        .vrout(vr_b), .tooth_idx(idx_b), .sync(sy_b), .rev_count(rev_b), .running(run_b),
        .cur_period(cur_b)
    );

    typedef struct {
        bit          rst;
        bit          en;
        logic [23:0] init, step, mn, mx;
        bit          vr;
        int          idx;
        bit          sy;
        int          rev;
        bit          run;
        logic [23:0] cur;
    } rec_t;

    typedef struct {
        logic [23:0] init, step, mn, mx;
        int          n_on, n_off;
    } run_t;

    rec_t stim_q[$];
    rec_t exp_q[$];
    int   n_cmp = 0, n_bad = 0;
    int   m_idx = 0, m_rev = 0;
    logic [23:0] m_cur = '0;

    function automatic logic [23:0] mclamp(input longint x, input logic [23:0] mn,
                                           input logic [23:0] mx);
        longint lo;
        lo = (mn == 0) ? 1 : longint'(mn);
        if (x < lo) x = lo;
        if (x > longint'(mx)) x = longint'(mx);
        return 24'(x);
    endfunction

    task automatic push(input bit r, input bit en, input logic [23:0] i, s, mn, mx, input bit vr,
                        input int idx, input bit sy, input int rev, input bit run,
                        input logic [23:0] cur);
        rec_t e;
        e.rst = r; e.en = en; e.init = i; e.step = s; e.mn = mn; e.mx = mx;
        e.vr = vr; e.idx = idx; e.sy = sy; e.rev = rev; e.run = run; e.cur = cur;
        stim_q.push_back(e);
    endtask

    task automatic gen_reset(input bit en, input int n_idle);
        m_idx = 0; m_rev = 0; m_cur = '0;
        push(1, en, 24'd4, 0, 1, 100, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n_idle; i++) push(0, 0, 24'd4, 0, 1, 100, 0, 0, 0, 0, 0, 0);
    endtask

    // Enable for n_on edges from IDLE, then one enable=0 edge (or a reset edge), then idle edges.
    task automatic gen_run(input logic [23:0] i, s, mn, mx, input int n_on, input int n_off,
                           input bit end_rst);
        int t = 1, k = 0, len, last_t;
        bit hi = 0, sy;
        logic [23:0] p, last_p;
        p = mclamp(longint'(i), mn, mx);
        last_t = t; last_p = p;
        for (int c = 0; c < n_on; c++) begin
            len = (!hi && t == 0) ? GAPM * int'(p) : int'(p);
            sy = hi && t == 0 && k == 0;
            if (sy) m_rev++;
            push(0, 1, i, s, mn, mx, hi, t, sy, m_rev, 1, p);
            last_t = t; last_p = p;
            k++;
            if (k >= len) begin
                k = 0;
                if (hi) begin
                    t = (t + 1) % N;
                    if (t != 0) p = mclamp(longint'(p) + longint'($signed(s)), mn, mx);
                end
                hi = !hi;
            end
        end
        if (end_rst) begin
            gen_reset(1, 0);
            return;
        end
        sy = hi && t == 0 && k == 0;
        if (sy) m_rev++;
        push(0, 0, i, s, mn, mx, 0, last_t, sy, m_rev, 0, last_p);
        for (int c = 0; c < n_off; c++) push(0, 0, i, s, mn, mx, 0, last_t, 0, m_rev, 0, last_p);
        m_idx = last_t; m_cur = last_p;
    endtask

    task automatic check(input string nm, input int cyc, input logic vr, input logic [5:0] idx,
                         input logic sy, input int rev, input logic run, input logic [23:0] cur,
                         input logic evr, input int erev, input rec_t e);
        n_cmp++;
        if (vr !== evr || idx !== 6'(e.idx) || sy !== e.sy || rev != erev || run !== e.run ||
            cur !== e.cur) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got vr=%b idx=%0d sync=%b rev=%0d run=%b cur=%0d | want vr=%b idx=%0d sync=%b rev=%0d run=%b cur=%0d",
                     nm, cyc, vr, idx, sy, rev, run, cur, evr, e.idx, e.sy, erev, e.run, e.cur);
        end
    endtask

    run_t runs[7];

    initial begin
        rec_t r, e;
        int cyc = 0;
        runs[0] = '{24'd4, 24'd0, 24'd1, 24'd100, 2420, 3};          // 5 revolutions, flat
        runs[1] = '{24'd4, 24'd1, 24'd1, 24'd6, 600, 2};             // ramp to max
        runs[2] = '{24'd10, 24'hFFFFFD, 24'd2, 24'd100, 200, 2};     // -3 to min
        runs[3] = '{24'd5, 24'hFFFFEC, 24'd2, 24'd100, 100, 2};      // -20 clamps
        runs[4] = '{24'd0, 24'd0, 24'd0, 24'd3, 300, 2};             // min 0 acts as 1
        runs[5] = '{24'd7, 24'd1, 24'd9, 24'd5, 100, 2};             // min > max
        runs[6] = '{24'd3, 24'h7FFFFF, 24'd1, 24'd8, 100, 2};        // large step to max

        gen_reset(0, 2);
        foreach (runs[j])
            gen_run(runs[j].init, runs[j].step, runs[j].mn, runs[j].mx, runs[j].n_on,
                    runs[j].n_off, 0);
        // Drop on the 2nd HIGH cycle of tooth 5, then restart.
        gen_run(24'd4, 24'd0, 24'd1, 24'd100, 38, 3, 0);
        gen_run(24'd4, 24'd0, 24'd1, 24'd100, 20, 2, 0);
        // Enable falls on the very edge that issues sync.
        gen_run(24'd4, 24'd0, 24'd1, 24'd100, 476, 2, 0);
        // Reset mid-gap with enable held high, then immediate restart.
        gen_run(24'd4, 24'd0, 24'd1, 24'd100, 466, 0, 1);
        gen_run(24'd4, 24'd0, 24'd1, 24'd100, 500, 2, 0);

        while (stim_q.size() > 0) begin
            r = stim_q.pop_front();
            rst = r.rst; enable = r.en;
            period_init = r.init; period_step = r.step; period_min = r.mn; period_max = r.mx;
            exp_q.push_back(r);
            @(posedge clk_efi);
            @(negedge clk_efi);
            e = exp_q.pop_front();
            check("dut_a", cyc, vr_a, idx_a, sy_a, int'(rev_a), run_a, cur_a, e.vr,
                  e.rev & 32'hFFFF, e);
            check("dut_b_inv", cyc, vr_b, idx_b, sy_b, int'(rev_b), run_b, cur_b, !e.vr,
                  e.rev & 3, e);
            cyc++;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trigger_wheel_gen.md
TRIGGER_WHEEL_GEN -- requirements
Module: trigger_wheel_gen

Interface
REQ-001 Parameter TEETH_TOTAL, 60, tooth positions per revolution, including missing positions; must be at least MISSING+2.
REQ-002 Parameter MISSING, 2, consecutive missing teeth forming the sync gap; must be at least 1.
REQ-003 Parameter PER_W, 24, width of half-period values in clocks.
REQ-004 Parameter REV_W, 16, width of the revolution counter.
REQ-005 Parameter INVERT, 0; when 1, vrout is inverted after all logic.
REQ-006 clk_efi  in  1  sole clock; all logic on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 enable  in  1  level; run while high.
REQ-009 period_init  in  PER_W  starting half-period, sampled on start.
REQ-010 period_step  in  PER_W  signed per-tooth half-period delta, sampled at each update.
REQ-011 period_min, period_max  in  PER_W each  unsigned clamp bounds; a period_min of 0 is treated as 1.
REQ-012 vrout  out  1  synthetic VR/hall tooth signal.
REQ-013 tooth_idx  out  clog2(N)  current present-tooth index, where N = TEETH_TOTAL-MISSING.
REQ-014 sync  out  1  one-cycle pulse on the rising edge of tooth 0.
REQ-015 rev_count  out  REV_W  completed revolutions, wrapping modulo 2^REV_W.
REQ-016 running  out  1  high when not IDLE.
REQ-017 cur_period  out  PER_W  active half-period.

Function
REQ-018 The block SHALL have exactly three states: IDLE, LOW and HIGH.
REQ-019 Start: in IDLE, enable=1 SHALL, next cycle, enter LOW with tooth_idx=1, running=1, and cur_period=clamp(period_init).
REQ-020 Each LOW or HIGH phase SHALL last exactly cur_period cycles, except the LOW phase of tooth 0, which SHALL last (2*MISSING+1)*cur_period cycles.
REQ-021 The gap length SHALL be produced by counting phase repetitions, not by a multiplier.
REQ-022 LOW to HIGH SHALL keep tooth_idx; HIGH to LOW SHALL advance tooth_idx, wrapping N-1 to 0.
REQ-023 Internal vrout SHALL be 0 in LOW and IDLE and 1 in HIGH.
REQ-024 sync SHALL pulse for exactly 1 cycle on the first HIGH cycle of tooth 0, and rev_count SHALL increment on that same cycle.
REQ-025 Period update: at the HIGH-to-LOW transition of every tooth except tooth 0, cur_period SHALL become clamp(cur_period + sign-extended period_step), computed in PER_W+2 bits.
REQ-026 clamp(x) SHALL return max(period_min,1) when x is below it, period_max when x is above it, and x otherwise; negative sums SHALL clamp to the minimum.
REQ-027 If period_min exceeds period_max, period_max SHALL win.
REQ-028 enable=0 in LOW or HIGH SHALL enter IDLE on the next cycle, with internal vrout=0, running=0, sync=0, and tooth_idx, rev_count and cur_period held.
REQ-029 A later restart SHALL begin again per REQ-019, and rev_count SHALL NOT clear.
REQ-030 Simultaneous events: if enable falls on the cycle a sync would be issued, sync and the rev_count increment SHALL still occur.
REQ-031 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-032 rst=1 SHALL, at the next edge and overriding every other input, set state=IDLE, internal vrout=0, tooth_idx=0, sync=0, rev_count=0, running=0 and cur_period=0.
REQ-033 Reset mid-phase SHALL abort immediately, with no sync pulse.
REQ-034 After rst falls with enable=1, operation SHALL start per REQ-019 one cycle later.

Verification
REQ-035 Defaults; init=4, step=0, min=1, max=100; enable held high -> teeth 1..57 each 4 low/4 high; tooth 0 is 20 low/4 high; sync every 480 cycles; rev_count increments by 1 per sync.
REQ-036 init=4, step=+1, max=6 -> half-periods 4,5,6,6,... with tooth 0 unchanged from the preceding tooth; tooth 0 gap is 30 cycles.
REQ-037 init=10, step=-3 (two's complement), min=2 -> half-periods 10,7,4,2,2; step=-20 from 5 -> clamps to 2.
REQ-038 enable dropped on the 2nd HIGH cycle of tooth 5 -> vrout=0 and running=0 next cycle; re-enable -> tooth_idx=1, cur_period=init.
REQ-039 REV_W=2, run 5 revolutions -> rev_count sequence 1,2,3,0,1; rst asserted mid-gap -> all outputs per REQ-032 next cycle, no sync.
REQ-040 INVERT=1 -> vrout is the exact complement of the REQ-035 trace, and reads 1 in IDLE and under reset.
